// File: rtl/qmfir_uart_tx.sv
// qmfir_uart_tx: serializes 24-bit read words to the host as three UART bytes, MSB byte first, LSB bit first.
// Latency: uart_txd falls on the acceptance edge; a word takes 30*CLKS_PER_BIT cycles (33* with parity).
// Backpressure: tx_ready is high only in IDLE; input changes and tx_valid pulses while busy are ignored.
// Build option: define QMFIR_UART_TX_PARITY_EN for 8E1 frames (even parity bit after data bit 7).
module qmfir_uart_tx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic [23:0] tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic        uart_txd,
    output logic        tx_busy
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

`ifdef QMFIR_UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]    r_bit, w_bit_nxt;
    logic [1:0]    r_byte, w_byte_nxt;
    logic [23:0]   r_hold, w_hold_nxt;
    logic [7:0]    r_shift, w_shift_nxt;
    logic          r_txd, w_txd_nxt;
    logic          w_bit_end;

    // Byte of the held word selected by a byte index (0 = [23:16]).
    function automatic logic [7:0] sel_byte(input logic [23:0] hold, input logic [1:0] idx);
        case (idx)
            2'd1:    sel_byte = hold[15:8];
            2'd2:    sel_byte = hold[7:0];
            default: sel_byte = hold[23:16];
        endcase
    endfunction

    assign w_bit_end = (r_cnt == BAUD_LAST);
    assign tx_ready  = (r_state == S_IDLE);
    assign tx_busy   = ~tx_ready;
    assign uart_txd  = r_txd;

    // Next-state logic; the line value is computed for the state being entered so it leaves a register.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_bit_nxt   = r_bit;
        w_byte_nxt  = r_byte;
        w_hold_nxt  = r_hold;
        w_shift_nxt = r_shift;
        w_txd_nxt   = r_txd;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                w_txd_nxt = 1'b1;
                if (tx_valid) begin
                    w_hold_nxt  = tx_data;
                    w_shift_nxt = tx_data[23:16];
                    w_byte_nxt  = 2'd0;
                    w_state_nxt = S_START;
                    w_txd_nxt   = 1'b0;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_cnt_nxt   = '0;
                    w_bit_nxt   = 3'd0;
                    w_state_nxt = S_DATA;
                    w_txd_nxt   = r_shift[0];
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = r_shift >> 1;
                    if (r_bit == 3'd7) begin
`ifdef QMFIR_UART_TX_PARITY_EN
                        w_state_nxt = S_PARITY;
                        w_txd_nxt   = ^sel_byte(r_hold, r_byte);
`else
                        w_state_nxt = S_STOP;
                        w_txd_nxt   = 1'b1;
`endif
                    end else begin
                        w_bit_nxt = r_bit + 3'd1;
                        w_txd_nxt = w_shift_nxt[0];
                    end
                end
            end
`ifdef QMFIR_UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_bit_end) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_STOP;
                    w_txd_nxt   = 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (w_bit_end) begin
                    w_cnt_nxt = '0;
                    if (r_byte < 2'd2) begin
                        // Next byte starts immediately: no idle gap inside a word.
                        w_byte_nxt  = r_byte + 2'd1;
                        w_shift_nxt = sel_byte(r_hold, r_byte + 2'd1);
                        w_state_nxt = S_START;
                        w_txd_nxt   = 1'b0;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_txd_nxt   = 1'b1;
                    end
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
                w_txd_nxt   = 1'b1;
            end
        endcase
    end

    // State and datapath registers; reset aborts any frame and forces the line high.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= 3'd0;
            r_byte  <= 2'd0;
            r_hold  <= 24'd0;
            r_shift <= 8'd0;
            r_txd   <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_byte  <= w_byte_nxt;
            r_hold  <= w_hold_nxt;
            r_shift <= w_shift_nxt;
            r_txd   <= w_txd_nxt;
        end
    end

endmodule

// File: tb/tb_qmfir_uart_tx.sv
// tb_qmfir_uart_tx: directed bench for qmfir_uart_tx at CLKS_PER_BIT=4 and CLKS_PER_BIT=2.
// Latency: each word is captured for its full frame length and decoded from line samples.
// Backpressure: exercises back-to-back acceptance and ignored tx_valid pulses while busy.
module tb_qmfir_uart_tx;

    logic        clk = 1'b0;
    logic        arst_n = 1'b1;
    logic [23:0] tx_data = 24'd0;
    logic        v4 = 1'b0;
    logic        v2 = 1'b0;
    logic        r4, t4, b4, r2, t2, b2;

    int checks = 0;
    int failures = 0;
    int sel = 4;
    int cpb = 4;
    logic s_txd [0:299];
    logic s_rdy [0:299];

`ifdef QMFIR_UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    qmfir_uart_tx #(.CLKS_PER_BIT(4)) u_dut4 (
        .clk(clk), .arst_n(arst_n), .tx_data(tx_data), .tx_valid(v4),
        .tx_ready(r4), .uart_txd(t4), .tx_busy(b4)
    );

    qmfir_uart_tx #(.CLKS_PER_BIT(2)) u_dut2 (
        .clk(clk), .arst_n(arst_n), .tx_data(tx_data), .tx_valid(v2),
        .tx_ready(r2), .uart_txd(t2), .tx_busy(b2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic cur_txd();
        return (sel == 2) ? t2 : t4;
    endfunction

    function automatic logic cur_rdy();
        return (sel == 2) ? r2 : r4;
    endfunction

    task automatic set_valid(input logic v);
        if (sel == 2) v2 = v;
        else          v4 = v;
    endtask

    // Samples the selected line at n consecutive negedges; optionally disturbs inputs while busy.
    task automatic capture(input int n, input int dis_at);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            s_txd[i] = cur_txd();
            s_rdy[i] = cur_rdy();
            if (i == dis_at) begin
                tx_data = 24'hFFFFFF;
                set_valid(1'b1);
            end
            if (i == dis_at + 2) set_valid(1'b0);
        end
    endtask

    // Called at a negedge with the selected DUT idle; sends one word and checks the whole frame.
    task automatic send_word(input string tag, input logic [23:0] word, input logic keep, input int dis_at);
        int         n;
        int         errs;
        int         base;
        logic [7:0] b;
        logic [7:0] got;
        logic       exp_bit;
        n = 3 * FB * cpb;
        tx_data = word;
        set_valid(1'b1);
        @(posedge clk);
        #1;
        check({tag, "_rdy_drop"}, 32'(cur_rdy()), 32'd0);
        if (!keep) set_valid(1'b0);
        capture(n, dis_at);
        errs = 0;
        for (int k = 0; k < 3; k++) begin
            b = 8'(word >> (16 - 8 * k));
            base = k * FB * cpb;
            got = 8'd0;
            for (int j = 0; j < 8; j++) got[j] = s_txd[base + (1 + j) * cpb + cpb / 2];
            check($sformatf("%s_byte%0d", tag, k), 32'(got), 32'(b));
            for (int t = 0; t < FB; t++) begin
                if (t == 0)                   exp_bit = 1'b0;
                else if (t <= 8)              exp_bit = b[t - 1];
                else if (FB == 11 && t == 9)  exp_bit = ^b;
                else                          exp_bit = 1'b1;
                for (int c = 0; c < cpb; c++)
                    if (s_txd[base + t * cpb + c] !== exp_bit) errs++;
            end
        end
        check({tag, "_bit_timing"}, 32'(errs), 32'd0);
        check({tag, "_busy_last"}, 32'(s_rdy[n - 1]), 32'd0);
        @(negedge clk);
        check({tag, "_rdy_back"}, 32'(cur_rdy()), 32'd1);
        check({tag, "_idle_line"}, 32'(cur_txd()), 32'd1);
    endtask

    initial begin
        int errs;
        #2 arst_n = 1'b0;
        #1;
        check("rst_txd4", 32'(t4), 32'd1);
        check("rst_rdy4", 32'(r4), 32'd1);
        check("rst_busy4", 32'(b4), 32'd0);
        check("rst_txd2", 32'(t2), 32'd1);
        check("rst_rdy2", 32'(r2), 32'd1);
        repeat (2) @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);

        sel = 4;
        cpb = 4;
        send_word("basic", 24'hA53C0F, 1'b0, -1);

        send_word("b2b_w0", 24'h000001, 1'b1, -1);
        send_word("b2b_w1", 24'hFFFFFF, 1'b0, -1);

        send_word("busy", 24'h123456, 1'b0, 5);
        capture(40, -1);
        errs = 0;
        for (int i = 0; i < 40; i++) if (s_txd[i] !== 1'b1 || s_rdy[i] !== 1'b1) errs++;
        check("busy_no_requeue", 32'(errs), 32'd0);

        send_word("par", 24'h010203, 1'b0, -1);
`ifdef QMFIR_UART_TX_PARITY_EN
        check("par_bit0", 32'(s_txd[0 * 44 + 9 * 4 + 2]), 32'd1);
        check("par_bit1", 32'(s_txd[1 * 44 + 9 * 4 + 2]), 32'd1);
        check("par_bit2", 32'(s_txd[2 * 44 + 9 * 4 + 2]), 32'd0);
`endif

        // Reset in the middle of byte 1's data bits
        tx_data = 24'hA50000;
        set_valid(1'b1);
        @(posedge clk);
        #1;
        set_valid(1'b0);
        repeat (50) @(negedge clk);
        check("rst_mid_pre_line", 32'(t4), 32'd0);
        check("rst_mid_pre_busy", 32'(b4), 32'd1);
        #2 arst_n = 1'b0;
        #1;
        check("rst_mid_txd", 32'(t4), 32'd1);
        check("rst_mid_rdy", 32'(r4), 32'd1);
        check("rst_mid_busy", 32'(b4), 32'd0);
        @(negedge clk);
        arst_n = 1'b1;
        capture(60, -1);
        errs = 0;
        for (int i = 0; i < 60; i++) if (s_txd[i] !== 1'b1 || s_rdy[i] !== 1'b1) errs++;
        check("rst_post_quiet", 32'(errs), 32'd0);

        sel = 2;
        cpb = 2;
        send_word("min", 24'h00FF80, 1'b0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
